zigzag_d1_merge: RTL and testbench



---
 rtl/izigzag_pkg.sv | 31 +++
 rtl/zigzag_d1_merge_if.sv | 41 ++++
 rtl/zz_out_reg.sv | 44 ++++
 rtl/zigzag_d1_merge.sv | 104 ++++++++++
 tb/tb_zigzag_d1_merge.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/izigzag_pkg.sv
// Shared zigzag lane definitions: lane/state enum, default region boundaries, coefficient width.
// Used by the lane merger (zigzag_d1_merge) and the inverse-zigzag splitter.
package izigzag_pkg;

  localparam int unsigned ZZ_W     = 16;
  localparam int unsigned ZZ_BND1  = 36;
  localparam int unsigned ZZ_BND2  = 50;
  localparam int unsigned ZZ_BND3  = 58;
  localparam int unsigned ZZ_BND4  = 64;
  localparam int unsigned ZZ_IDX_W = 7;
  localparam int unsigned ZZ_NLANE = 8;

  typedef enum logic [2:0] {LA, LB, LC, LD, LE, LF, LG, LH} lane_e;

  // Lanes alternate pairwise inside each region: A/B, C/D, E/F, G/H.
  function automatic lane_e zz_partner(input lane_e s);
    lane_e p;
    case (s)
      LA:      p = LB;
      LB:      p = LA;
      LC:      p = LD;
      LD:      p = LC;
      LE:      p = LF;
      LF:      p = LE;
      LG:      p = LH;
      default: p = LG;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/zigzag_d1_merge_if.sv
// Lane and serial handshake bundle for zigzag_d1_merge.
// ruS_last exists only when ZZ_MERGE_LAST_EN is defined.
interface zigzag_d1_merge_if #(
  parameter int unsigned W = izigzag_pkg::ZZ_W
);

  logic [W-1:0] chuA_d, chuB_d, chuC_d, chuD_d, chuE_d, chuF_d, chuG_d, chuH_d;
  logic         chuA_v, chuB_v, chuC_v, chuD_v, chuE_v, chuF_v, chuG_v, chuH_v;
  logic         chuA_r, chuB_r, chuC_r, chuD_r, chuE_r, chuF_r, chuG_r, chuH_r;
  logic [W-1:0] ruS_d;
  logic         ruS_v;
  logic         ruS_r;
`ifdef ZZ_MERGE_LAST_EN
  logic         ruS_last;
`endif

  // Merger side: consumes lanes, produces the serial stream.
  modport slave (
    input  chuA_d, chuB_d, chuC_d, chuD_d, chuE_d, chuF_d, chuG_d, chuH_d,
    input  chuA_v, chuB_v, chuC_v, chuD_v, chuE_v, chuF_v, chuG_v, chuH_v,
    output chuA_r, chuB_r, chuC_r, chuD_r, chuE_r, chuF_r, chuG_r, chuH_r,
`ifdef ZZ_MERGE_LAST_EN
    output ruS_last,
`endif
    output ruS_d, ruS_v,
    input  ruS_r
  );

  // Environment side: drives lanes, sinks the serial stream.
  modport master (
    output chuA_d, chuB_d, chuC_d, chuD_d, chuE_d, chuF_d, chuG_d, chuH_d,
    output chuA_v, chuB_v, chuC_v, chuD_v, chuE_v, chuF_v, chuG_v, chuH_v,
    input  chuA_r, chuB_r, chuC_r, chuD_r, chuE_r, chuF_r, chuG_r, chuH_r,
`ifdef ZZ_MERGE_LAST_EN
    input  ruS_last,
`endif
    input  ruS_d, ruS_v,
    output ruS_r
  );

endinterface

// File: rtl/zz_out_reg.sv
// Single-entry valid/ready register slice; accepts a new word while the held one drains.
module zz_out_reg #(
  parameter int unsigned DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_v_i,
  input  logic [DW-1:0] in_d_i,
  output logic          in_r_o,
  output logic [DW-1:0] out_d_o,
  output logic          out_v_o,
  input  logic          out_r_i
);

  logic          v_q, v_d;
  logic [DW-1:0] d_q, d_d;

  assign in_r_o = ~v_q | out_r_i;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (in_v_i && in_r_o) begin
      v_d = 1'b1;
      d_d = in_d_i;
    end else if (out_r_i) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign out_d_o = d_q;
  assign out_v_o = v_q;

endmodule

// File: rtl/zigzag_d1_merge.sv
// Merges eight zigzag lanes (A..H) into a serial stream of 64-word coefficient blocks.
// Optional ruS_last block-end flag under ZZ_MERGE_LAST_EN.
module zigzag_d1_merge
  import izigzag_pkg::*;
#(
  parameter int unsigned W    = ZZ_W,
  parameter int unsigned BND1 = ZZ_BND1,
  parameter int unsigned BND2 = ZZ_BND2,
  parameter int unsigned BND3 = ZZ_BND3,
  parameter int unsigned BND4 = ZZ_BND4
) (
  input  logic             clock,
  input  logic             reset,
  zigzag_d1_merge_if.slave bus
);

  localparam int unsigned IDX_W = ZZ_IDX_W;
`ifdef ZZ_MERGE_LAST_EN
  localparam int unsigned DW = W + 1;
`else
  localparam int unsigned DW = W;
`endif

  lane_e                  state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d, idx_nx;
  logic                   phase_q, phase_d;
  logic [W-1:0]           lane_d [ZZ_NLANE];
  logic [ZZ_NLANE-1:0]    lane_v, lane_r;
  logic                   slot_r, take;
  logic [DW-1:0]          in_word, out_word;

  assign lane_d[0] = bus.chuA_d;
  assign lane_d[1] = bus.chuB_d;
  assign lane_d[2] = bus.chuC_d;
  assign lane_d[3] = bus.chuD_d;
  assign lane_d[4] = bus.chuE_d;
  assign lane_d[5] = bus.chuF_d;
  assign lane_d[6] = bus.chuG_d;
  assign lane_d[7] = bus.chuH_d;
  assign lane_v    = {bus.chuH_v, bus.chuG_v, bus.chuF_v, bus.chuE_v,
                      bus.chuD_v, bus.chuC_v, bus.chuB_v, bus.chuA_v};
  assign {bus.chuH_r, bus.chuG_r, bus.chuF_r, bus.chuE_r,
          bus.chuD_r, bus.chuC_r, bus.chuB_r, bus.chuA_r} = lane_r;

  assign idx_nx = idx_q + IDX_W'(1);

  // Lane select and region walk; readies are held low while reset is asserted.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    phase_d        = phase_q;
    lane_r         = '0;
    lane_r[state_q] = slot_r & reset;
    take           = lane_v[state_q] & lane_r[state_q];
    if (take) begin
      idx_d   = idx_nx;
      phase_d = ~phase_q;
      if (phase_q) begin
        if (idx_nx == IDX_W'(BND1))      state_d = LC;
        else if (idx_nx == IDX_W'(BND2)) state_d = LE;
        else if (idx_nx == IDX_W'(BND3)) state_d = LG;
        else if (idx_nx == IDX_W'(BND4)) begin
          state_d = LA;
          idx_d   = '0;
        end else begin
          state_d = zz_partner(state_q);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= LA;
      idx_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
    end
  end

`ifdef ZZ_MERGE_LAST_EN
  assign in_word = {(idx_q == IDX_W'(BND4 - 1)), lane_d[state_q]};
  assign bus.ruS_last = out_word[W];
`else
  assign in_word = lane_d[state_q];
`endif

  zz_out_reg #(.DW(DW)) u_out (
    .clock   (clock),
    .reset   (reset),
    .in_v_i  (take),
    .in_d_i  (in_word),
    .in_r_o  (slot_r),
    .out_d_o (out_word),
    .out_v_o (bus.ruS_v),
    .out_r_i (bus.ruS_r)
  );

  assign bus.ruS_d = out_word[W-1:0];

endmodule

// File: tb/tb_zigzag_d1_merge.sv
// Scoreboard bench for zigzag_d1_merge; checks ruS_last when ZZ_MERGE_LAST_EN is defined.
module tb_zigzag_d1_merge;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] d;
    int           idx;
  } exp_t;

  logic         clock;
  logic         reset;
  logic [W-1:0] drv_d [8];
  logic         drv_v [8];
  logic         srdy;
  logic [7:0]   rdy;

  int errors = 0;
  int checks = 0;

  exp_t         exp_q [$];
  logic [W-1:0] lane_q [8][$];
  int           tot [8];
  int           gen_idx = 0;
  bit           in_reset = 1'b1;
  int           pv = 100;
  int           pr = 100;
  bit           hold_arm = 1'b0;
  int           hold = 0;
  logic [W-1:0] held = '0;
  bit           bdrop_arm = 1'b0;
  int           bdrop = 0;

  zigzag_d1_merge_if #(.W(W)) bus ();

  zigzag_d1_merge #(.W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign bus.chuA_d = drv_d[0];  assign bus.chuA_v = drv_v[0];
  assign bus.chuB_d = drv_d[1];  assign bus.chuB_v = drv_v[1];
  assign bus.chuC_d = drv_d[2];  assign bus.chuC_v = drv_v[2];
  assign bus.chuD_d = drv_d[3];  assign bus.chuD_v = drv_v[3];
  assign bus.chuE_d = drv_d[4];  assign bus.chuE_v = drv_v[4];
  assign bus.chuF_d = drv_d[5];  assign bus.chuF_v = drv_v[5];
  assign bus.chuG_d = drv_d[6];  assign bus.chuG_v = drv_v[6];
  assign bus.chuH_d = drv_d[7];  assign bus.chuH_v = drv_v[7];
  assign bus.ruS_r  = srdy;
  assign rdy = {bus.chuH_r, bus.chuG_r, bus.chuF_r, bus.chuE_r,
                bus.chuD_r, bus.chuC_r, bus.chuB_r, bus.chuA_r};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference lane for a block index: regions [0,36) A/B, [36,50) C/D, [50,58) E/F, [58,64) G/H,
  // each region alternating lanes every two words starting with its first lane.
  function automatic int lane_of(input int idx);
    int base, off;
    if (idx < 36)      begin base = 0; off = idx;      end
    else if (idx < 50) begin base = 2; off = idx - 36; end
    else if (idx < 58) begin base = 4; off = idx - 50; end
    else               begin base = 6; off = idx - 58; end
    return base + ((off / 2) % 2);
  endfunction

  // Tag = {lane, index, random}; queued on its lane and on the expected output order.
  task automatic gen(input int n);
    for (int k = 0; k < n; k++) begin
      int           l;
      logic [W-1:0] d;
      exp_t         e;
      l = lane_of(gen_idx);
      d = {3'(l), 6'(gen_idx), 7'($urandom)};
      lane_q[l].push_back(d);
      e.d   = d;
      e.idx = gen_idx;
      exp_q.push_back(e);
      gen_idx = (gen_idx + 1) % 64;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Lane and sink driver: drives at negedge, accounts lane handshakes just before posedge.
  initial begin : driver
    for (int l = 0; l < 8; l++) begin
      drv_v[l] = 1'b0;
      drv_d[l] = '0;
    end
    srdy = 1'b1;
    forever begin
      @(negedge clock);
      if (in_reset) begin
        for (int l = 0; l < 8; l++) drv_v[l] = 1'b0;
        srdy = 1'b1;
      end else begin
        if (hold_arm && bus.ruS_v && bus.ruS_d[12:7] == 6'd10) begin
          hold_arm = 1'b0;
          hold     = 5;
          held     = bus.ruS_d;
        end
        if (bdrop_arm && bus.ruS_v && bus.ruS_d[12:7] == 6'd1) begin
          bdrop_arm = 1'b0;
          bdrop     = 3;
        end
        for (int l = 0; l < 8; l++) begin
          drv_v[l] = (lane_q[l].size() != 0) && ($urandom_range(99) < pv) && !(l == 1 && bdrop > 0);
          drv_d[l] = (lane_q[l].size() != 0) ? lane_q[l][0] : '0;
        end
        srdy = (hold > 0) ? 1'b0 : ($urandom_range(99) < pr);
        #4;
        if (!in_reset) begin
          if (hold > 0) begin
            chk("stall_data_stable", 32'(bus.ruS_d), 32'(held));
            chk("stall_ready_low", 32'(rdy), 32'd0);
            hold--;
          end
          if (bdrop > 0) begin
            chk("bubble_other_ready", 32'(rdy & 8'hFD), 32'd0);
            if (bdrop < 3) chk("bubble_out_valid", 32'(bus.ruS_v), 32'd0);
            bdrop--;
          end
          for (int l = 0; l < 8; l++) begin
            if (drv_v[l] && rdy[l]) begin
              void'(lane_q[l].pop_front());
              tot[l]++;
            end
          end
        end
      end
    end
  end

  // Output monitor: pops the expected order on every serial handshake.
  initial begin : monitor
    forever begin
      @(negedge clock);
      #4;
      if (!in_reset) begin
        chk("ready_onehot0", 32'($countones(rdy) <= 1), 32'd1);
        if (bus.ruS_v && srdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 32'(bus.ruS_d), 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("serial_word", 32'(bus.ruS_d), 32'(e.d));
`ifdef ZZ_MERGE_LAST_EN
            chk("serial_last", 32'(bus.ruS_last), 32'(e.idx == 63));
`endif
          end
        end
      end
    end
  end

  initial begin : main
    int gaps_ok;
    int found;
    for (int l = 0; l < 8; l++) tot[l] = 0;
    reset = 1'b0;
    #12;
    chk("rst_valid", 32'(bus.ruS_v), 32'd0);
    chk("rst_data", 32'(bus.ruS_d), 32'd0);
    chk("rst_ready", 32'(rdy), 32'd0);
`ifdef ZZ_MERGE_LAST_EN
    chk("rst_last", 32'(bus.ruS_last), 32'd0);
`endif
    @(negedge clock);
    reset    = 1'b1;
    in_reset = 1'b0;

    // Full throughput across two blocks.
    gen(128);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clock);
      #3;
      if (bus.ruS_v) found = 1;
    end
    chk("first_word_seen", 32'(found), 32'd1);
    gaps_ok = 0;
    for (int i = 0; i < 64; i++) begin
      if (bus.ruS_v && srdy) gaps_ok++;
      @(negedge clock);
      #3;
    end
    chk("back_to_back_64", 32'(gaps_ok), 32'd64);
    drain(300);

    // Downstream stall at index 10.
    hold_arm = 1'b1;
    gen(64);
    drain(300);
    chk("stall_taken", 32'(hold_arm), 32'd0);

    // Lane B bubble at the first B pair.
    bdrop_arm = 1'b1;
    gen(64);
    drain(300);
    chk("bubble_taken", 32'(bdrop_arm), 32'd0);

    // Asynchronous reset mid-block.
    gen(64);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clock);
      #2;
      if (bus.ruS_v && bus.ruS_d[12:7] == 6'd45) found = 1;
    end
    chk("reached_idx45", 32'(found), 32'd1);
    reset    = 1'b0;
    in_reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.ruS_v), 32'd0);
    chk("midrst_data", 32'(bus.ruS_d), 32'd0);
    chk("midrst_ready", 32'(rdy), 32'd0);
`ifdef ZZ_MERGE_LAST_EN
    chk("midrst_last", 32'(bus.ruS_last), 32'd0);
`endif
    exp_q.delete();
    for (int l = 0; l < 8; l++) lane_q[l].delete();
    gen_idx = 0;
    repeat (3) @(negedge clock);
    reset    = 1'b1;
    in_reset = 1'b0;
    gen(64);
    drain(300);

    // Random valid/ready over two blocks with lane totals.
    for (int l = 0; l < 8; l++) tot[l] = 0;
    pv = 70;
    pr = 60;
    gen(128);
    drain(4000);
    chk("total_A", 32'(tot[0]), 32'd36);
    chk("total_B", 32'(tot[1]), 32'd36);
    chk("total_C", 32'(tot[2]), 32'd16);
    chk("total_D", 32'(tot[3]), 32'd12);
    chk("total_E", 32'(tot[4]), 32'd8);
    chk("total_F", 32'(tot[5]), 32'd8);
    chk("total_G", 32'(tot[6]), 32'd8);
    chk("total_H", 32'(tot[7]), 32'd4);

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
